// File: rtl/bitmap_pixel_sequencer_if.sv
// Word-fetch and pixel-stream handshake bundle between the bitmap sequencer and its neighbours.
// The master modport is the sequencer; the slave modport is the word source / pixel sink side.
interface bitmap_pixel_sequencer_if #(
   parameter int unsigned WORD_W  = 16,
   parameter int unsigned COLOR_W = 12
);
   logic [WORD_W-1:0]  word_data;
   logic               word_valid;
   logic               word_ready;
   logic               pix_valid;
   logic               pix_ready;
   logic [COLOR_W-1:0] pix_color;
   logic               line_end;
   logic               frame_end;

   modport master (
      input  word_data, word_valid, pix_ready,
      output word_ready, pix_valid, pix_color, line_end, frame_end
   );

   modport slave (
      output word_data, word_valid, pix_ready,
      input  word_ready, pix_valid, pix_color, line_end, frame_end
   );
endinterface

// File: rtl/bitmap_pixel_sequencer.sv
// Frame-level 1-bpp bitmap expander: fetches packed words, emits fg/bg pixels MSB first,
// each repeated 'scale' times, with line/frame position markers. All outputs registered.
module bitmap_pixel_sequencer #(
   parameter int unsigned WORD_W  = 16,
   parameter int unsigned COLOR_W = 12,
   parameter int unsigned H_PIX   = 640,
   parameter int unsigned V_LINES = 480,
   parameter int unsigned SCALE_W = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [SCALE_W-1:0]  scale_i,
   input  logic [COLOR_W-1:0]  fg_color_i,
   input  logic [COLOR_W-1:0]  bg_color_i,
   output logic                busy_o,
   bitmap_pixel_sequencer_if.master bus
);

   localparam int unsigned X_W = (H_PIX > 1)   ? $clog2(H_PIX)   : 1;
   localparam int unsigned Y_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
   localparam int unsigned B_W = (WORD_W > 1)  ? $clog2(WORD_W)  : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAW  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [X_W-1:0]     x_q, x_d;
   logic [Y_W-1:0]     y_q, y_d;
   logic [B_W-1:0]     bit_q, bit_d;
   logic [SCALE_W-1:0] rep_q, rep_d;
   logic [SCALE_W-1:0] scale_q, scale_d;
   logic [WORD_W-1:0]  shreg_q, shreg_d;

   logic               word_ready_q, word_ready_d;
   logic               pix_valid_q, pix_valid_d;
   logic [COLOR_W-1:0] pix_color_q, pix_color_d;
   logic               line_end_q, line_end_d;
   logic               frame_end_q, frame_end_d;
   logic               busy_q, busy_d;

   logic word_xfer, pix_xfer, pix_stall;
   logic rep_last, bit_last, x_last, y_last;

   // Next-state for FSM, counters and shift register, then output decode from next state
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      bit_d     = bit_q;
      rep_d     = rep_q;
      scale_d   = scale_q;
      shreg_d   = shreg_q;

      word_xfer = word_ready_q && bus.word_valid;
      pix_xfer  = pix_valid_q && bus.pix_ready;
      pix_stall = pix_valid_q && !bus.pix_ready;
      rep_last  = (rep_q == (scale_q - SCALE_W'(1)));
      bit_last  = (bit_q == B_W'(WORD_W - 1));
      x_last    = (x_q == X_W'(H_PIX - 1));
      y_last    = (y_q == Y_W'(V_LINES - 1));

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               scale_d = (scale_i == '0) ? SCALE_W'(1) : scale_i;
               x_d     = '0;
               y_d     = '0;
               bit_d   = '0;
               rep_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (word_xfer) begin
               shreg_d = bus.word_data;
               bit_d   = '0;
               rep_d   = '0;
               state_d = S_DRAW;
            end
         end
         S_DRAW: begin
            if (pix_xfer) begin
               x_d = x_q + X_W'(1);
               if (rep_last) begin
                  rep_d   = '0;
                  shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                  bit_d   = bit_q + B_W'(1);
               end else begin
                  rep_d = rep_q + SCALE_W'(1);
               end
               // Every line starts on a fresh word; leftover bits are dropped
               if (x_last) begin
                  x_d   = '0;
                  rep_d = '0;
                  bit_d = '0;
                  if (y_last) begin
                     y_d     = '0;
                     state_d = S_DONE;
                  end else begin
                     y_d     = y_q + Y_W'(1);
                     state_d = S_FETCH;
                  end
               end else if (bit_last && rep_last) begin
                  bit_d   = '0;
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort_i && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end

      word_ready_d = (state_d == S_FETCH);
      pix_valid_d  = (state_d == S_DRAW);
      busy_d       = (state_d == S_FETCH) || (state_d == S_DRAW);
      line_end_d   = (state_d == S_DRAW) && (x_d == X_W'(H_PIX - 1));
      frame_end_d  = line_end_d && (y_d == Y_W'(V_LINES - 1));

      // A stalled beat keeps its colour so the sink sees a stable payload
      if (state_d != S_DRAW) begin
         pix_color_d = '0;
      end else if (pix_stall) begin
         pix_color_d = pix_color_q;
      end else begin
         pix_color_d = shreg_d[WORD_W-1] ? fg_color_i : bg_color_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         bit_q        <= '0;
         rep_q        <= '0;
         scale_q      <= '0;
         shreg_q      <= '0;
         word_ready_q <= 1'b0;
         pix_valid_q  <= 1'b0;
         pix_color_q  <= '0;
         line_end_q   <= 1'b0;
         frame_end_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         bit_q        <= bit_d;
         rep_q        <= rep_d;
         scale_q      <= scale_d;
         shreg_q      <= shreg_d;
         word_ready_q <= word_ready_d;
         pix_valid_q  <= pix_valid_d;
         pix_color_q  <= pix_color_d;
         line_end_q   <= line_end_d;
         frame_end_q  <= frame_end_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.word_ready = word_ready_q;
   assign bus.pix_valid  = pix_valid_q;
   assign bus.pix_color  = pix_color_q;
   assign bus.line_end   = line_end_q;
   assign bus.frame_end  = frame_end_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_bitmap_pixel_sequencer.sv
// Bench for bitmap_pixel_sequencer: table-driven frames, hand-written corner sequences,
// and randomized frames against a queue-based reference model.
module tb_bitmap_pixel_sequencer;

   localparam int unsigned WORD_W  = 4;
   localparam int unsigned COLOR_W = 12;
   localparam int unsigned H_PIX   = 8;
   localparam int unsigned V_LINES = 2;
   localparam int unsigned SCALE_W = 3;

   typedef struct packed {
      logic px;
      logic le;
      logic fe;
   } exp_t;

   typedef struct {
      logic [2:0]  sc;
      logic [15:0] words;
      int          nw;
      logic [15:0] pix;
   } vec_t;

   logic               clk;
   logic               reset;
   logic               start;
   logic               abort;
   logic [SCALE_W-1:0] scale;
   logic [COLOR_W-1:0] fg;
   logic [COLOR_W-1:0] bg;
   logic               busy;

   int checks;
   int errors;

   logic [WORD_W-1:0] word_q[$];
   exp_t              exp_q[$];
   int                exp_words;
   vec_t              tbl[5];

   bitmap_pixel_sequencer_if #(.WORD_W(WORD_W), .COLOR_W(COLOR_W)) bus ();

   bitmap_pixel_sequencer #(
      .WORD_W(WORD_W), .COLOR_W(COLOR_W), .H_PIX(H_PIX),
      .V_LINES(V_LINES), .SCALE_W(SCALE_W)
   ) dut (
      .clk(clk), .reset(reset), .start_i(start), .abort_i(abort), .scale_i(scale),
      .fg_color_i(fg), .bg_color_i(bg), .busy_o(busy), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: fill each line from fresh words, MSB first, each bit repeated scale times
   task automatic build_model(input logic [2:0] sc);
      int s, k, n;
      logic [WORD_W-1:0] cur;
      s = (sc == 3'd0) ? 1 : int'(sc);
      k = 0;
      exp_q.delete();
      for (int ln = 0; ln < int'(V_LINES); ln++) begin
         n = 0;
         while (n < int'(H_PIX)) begin
            cur = word_q[k];
            k++;
            for (int b = int'(WORD_W) - 1; b >= 0; b--) begin
               for (int r = 0; r < s; r++) begin
                  if (n < int'(H_PIX)) begin
                     exp_q.push_back('{cur[b], n == int'(H_PIX) - 1,
                                       (n == int'(H_PIX) - 1) && (ln == int'(V_LINES) - 1)});
                     n++;
                  end
               end
            end
         end
      end
      exp_words = k;
   endtask

   task automatic load_vec(input vec_t v);
      logic [15:0] w;
      logic [15:0] p;
      w = v.words;
      p = v.pix;
      word_q.delete();
      exp_q.delete();
      for (int i = 0; i < v.nw; i++) word_q.push_back(w[15-4*i -: 4]);
      for (int i = 0; i < 16; i++) exp_q.push_back('{p[15-i], (i % 8) == 7, i == 15});
      exp_words = v.nw;
   endtask

   // Runs one frame from IDLE, checking every pixel beat, stall stability and DONE behaviour
   task automatic run_frame(input logic [2:0] sc, input int vp, input int rp, input int stall_at);
      int wi, pi, cyc, stall_left;
      logic held, h_le;
      logic [COLOR_W-1:0] h_col;
      wi = 0; pi = 0; cyc = 0; stall_left = 3; held = 1'b0; h_le = 1'b0; h_col = '0;
      @(negedge clk);
      start = 1'b1;
      scale = sc;
      @(negedge clk);
      start = 1'b0;
      scale = 3'($urandom);
      while (pi < exp_q.size() && cyc < 1000) begin
         if (held) begin
            chk("stall_valid", 32'(bus.pix_valid), 32'd1);
            chk("stall_color", 32'(bus.pix_color), 32'(h_col));
            chk("stall_line_end", 32'(bus.line_end), 32'(h_le));
         end
         bus.word_valid = (wi < word_q.size()) && ($urandom_range(99) < vp);
         bus.word_data  = (wi < word_q.size()) ? word_q[wi] : '0;
         if (stall_at == pi && stall_left > 0 && bus.pix_valid) begin
            bus.pix_ready = 1'b0;
            stall_left--;
         end else begin
            bus.pix_ready = ($urandom_range(99) < rp);
         end
         if (bus.word_valid && bus.word_ready) wi++;
         held  = bus.pix_valid && !bus.pix_ready;
         h_col = bus.pix_color;
         h_le  = bus.line_end;
         if (bus.pix_valid && bus.pix_ready) begin
            chk("pix_color", 32'(bus.pix_color), 32'(exp_q[pi].px ? fg : bg));
            chk("line_end", 32'(bus.line_end), 32'(exp_q[pi].le));
            chk("frame_end", 32'(bus.frame_end), 32'(exp_q[pi].fe));
            pi++;
         end
         @(negedge clk);
         cyc++;
      end
      if (pi < exp_q.size()) chk("frame_timeout", 32'(pi), 32'(exp_q.size()));
      bus.word_valid = 1'b0;
      bus.pix_ready  = 1'b0;
      chk("words_used", 32'(wi), 32'(exp_words));
      chk("done_outputs", {29'd0, busy, bus.pix_valid, bus.word_ready}, 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_start_ignored", 32'(busy), 32'd0);
      @(negedge clk);
      chk("idle_after_done", {30'd0, busy, bus.word_ready}, 32'd0);
   endtask

   initial begin
      int pi, wi, cyc;
      logic hit;
      checks = 0;
      errors = 0;
      reset = 1'b0; start = 1'b0; abort = 1'b0; scale = '0;
      fg = 12'hFFF; bg = 12'h000;
      bus.word_valid = 1'b0; bus.word_data = '0; bus.pix_ready = 1'b0;

      tbl[0] = '{3'd1, 16'hA6F0, 4, 16'hA6F0};
      tbl[1] = '{3'd3, 16'h8C00, 2, 16'hE0FC};
      tbl[2] = '{3'd0, 16'hA6F0, 4, 16'hA6F0};
      tbl[3] = '{3'd2, 16'h9500, 2, 16'hC333};
      tbl[4] = '{3'd7, 16'h8000, 2, 16'hFE00};

      repeat (2) @(negedge clk);
      chk("reset_outputs", {13'd0, busy, bus.pix_valid, bus.word_ready, bus.line_end,
                            bus.frame_end, bus.pix_color}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {29'd0, busy, bus.pix_valid, bus.word_ready}, 32'd0);

      for (int i = 0; i < 5; i++) begin
         load_vec(tbl[i]);
         run_frame(tbl[i].sc, 100, 100, -1);
      end

      // Back-pressure on pixel 2 and on the line-end beat
      load_vec(tbl[0]);
      run_frame(3'd1, 100, 100, 2);
      run_frame(3'd1, 100, 100, 7);

      // Source starves the fetch for 5 cycles
      @(negedge clk);
      start = 1'b1; scale = 3'd1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("starve_ready", 32'(bus.word_ready), 32'd1);
         chk("starve_valid", 32'(bus.pix_valid), 32'd0);
         @(negedge clk);
      end
      bus.word_valid = 1'b1; bus.word_data = 4'hA; bus.pix_ready = 1'b0;
      @(negedge clk);
      bus.word_valid = 1'b0;
      chk("first_pix_valid", {30'd0, bus.pix_valid, bus.word_ready}, 32'd2);
      chk("first_pix_color", 32'(bus.pix_color), 32'hFFF);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_in_draw", {29'd0, busy, bus.pix_valid, bus.word_ready}, 32'd0);

      // Abort while pixel 5 of line 0 transfers, then a full restart
      load_vec(tbl[0]);
      @(negedge clk);
      start = 1'b1; scale = 3'd1;
      @(negedge clk);
      start = 1'b0;
      pi = 0; wi = 0; cyc = 0; hit = 1'b0;
      while (!hit && cyc < 200) begin
         bus.word_valid = 1'b1;
         bus.word_data  = word_q[wi];
         bus.pix_ready  = 1'b1;
         if (bus.word_valid && bus.word_ready) wi++;
         if (bus.pix_valid) begin
            if (pi == 4) begin
               abort = 1'b1;
               hit = 1'b1;
            end
            pi++;
         end
         @(negedge clk);
         cyc++;
      end
      abort = 1'b0; bus.word_valid = 1'b0; bus.pix_ready = 1'b0;
      chk("abort_reached", 32'(hit), 32'd1);
      chk("abort_idle", {29'd0, busy, bus.pix_valid, bus.word_ready}, 32'd0);
      @(negedge clk);
      chk("abort_stays_idle", {30'd0, busy, bus.word_ready}, 32'd0);
      run_frame(3'd1, 100, 100, -1);

      // Asynchronous reset in the middle of a draw
      @(negedge clk);
      start = 1'b1; scale = 3'd1;
      @(negedge clk);
      start = 1'b0;
      bus.word_valid = 1'b1; bus.word_data = 4'hA; bus.pix_ready = 1'b0;
      cyc = 0;
      while (!bus.pix_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      bus.word_valid = 1'b0;
      chk("draw_before_reset", 32'(bus.pix_color), 32'hFFF);
      reset = 1'b0;
      #1;
      chk("async_reset", {13'd0, busy, bus.pix_valid, bus.word_ready, bus.line_end,
                          bus.frame_end, bus.pix_color}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_after_async", {29'd0, busy, bus.pix_valid, bus.word_ready}, 32'd0);

      // Randomized frames against the reference model
      for (int n = 0; n < 12; n++) begin
         logic [2:0] sc;
         sc = 3'($urandom_range(7));
         fg = 12'($urandom);
         bg = ~fg;
         word_q.delete();
         for (int k = 0; k < 8; k++) word_q.push_back(4'($urandom));
         build_model(sc);
         run_frame(sc, 60, 60, (n % 3 == 0) ? int'($urandom_range(15)) : -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
